// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared encodings for the RAM-port arbiter.
//   - access size encodings carried on ls_size
//   - controller state and grant-owner enumerations
//   - helpers: byte count for a size code, IO-space address test
package mem_ctrl_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IC = 1'b0,
    GNT_LS = 1'b1
  } gnt_e;

  // Number of byte beats for a size code; unknown codes fall back to a word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Addresses with bits [17:16] = 2'b11 map to the IO block (UART).
  function automatic logic is_io(input logic [31:0] addr);
    return addr[17:16] == 2'b11;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates the byte-wide RAM port between icache word refills
// and load/store buffer accesses, serialising each grant into byte beats.
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global pause)
//   mem_din/mem_dout/mem_a/mem_wr : RAM pins (read data one cycle after address)
//   io_buffer_full                : stalls IO-space writes
//   flush                         : cancels icache reads
//   ic_req/ic_addr -> ic_done/ic_data             : icache word reads
//   ls_req/ls_wr/ls_addr/ls_size/ls_wdata -> ls_done/ls_rdata : LSB accesses
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        flush,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic        ic_done,
  output logic [31:0] ic_data,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [31:0] ls_addr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata
);

  state_e      state_q, state_d;
  gnt_e        owner_q, owner_d;
  gnt_e        last_grant_q, last_grant_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  nbytes_q, nbytes_d;
  // READ: edges elapsed since grant. WRITE: bytes already written.
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mem_a_q, mem_a_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic        mem_wr_q, mem_wr_d;
  logic        ic_done_q, ic_done_d;
  logic        ls_done_q, ls_done_d;
  logic [31:0] ic_data_q, ic_data_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;

  logic        ic_want, gnt_ls, gnt_ic, grant;
  logic        g_wr, g_stall;
  logic [31:0] g_addr, cur_addr;
  logic [2:0]  g_n;
  logic [1:0]  cap_idx;
  logic        abort, rd_last, wr_last, wr_stall;

  // A flushed fetch must not win arbitration in the same cycle.
  assign ic_want = ic_req & ~flush;
  assign gnt_ls  = ls_req & (~ic_want | (last_grant_q == GNT_IC));
  assign gnt_ic  = ic_want & ~gnt_ls;
  // Holding off while a done pulse is visible gives the mandatory idle bubble,
  // so a requester that still shows its old request is not re-granted.
  assign grant   = (state_q == ST_IDLE) & ~ic_done_q & ~ls_done_q & (gnt_ls | gnt_ic);

  assign g_addr  = gnt_ls ? ls_addr : ic_addr;
  assign g_wr    = gnt_ls & ls_wr;
  assign g_n     = gnt_ls ? size_bytes(ls_size) : 3'd4;
  assign g_stall = g_wr & is_io(g_addr) & io_buffer_full;

  assign cur_addr = addr_q + {29'd0, cnt_q};
  // Byte captured at edge k+2 belongs to address k; cnt 2..5 wraps to 0..3.
  assign cap_idx  = cnt_q[1:0] - 2'd2;
  assign abort    = (state_q == ST_READ) & (owner_q == GNT_IC) & flush;
  assign rd_last  = (state_q == ST_READ) & (cnt_q == nbytes_q + 3'd1);
  assign wr_last  = (state_q == ST_WRITE) & (cnt_q == nbytes_q);
  assign wr_stall = is_io(cur_addr) & io_buffer_full;

  // State register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
    end else if (rdy_in) begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (grant) state_d = g_wr ? ST_WRITE : ST_READ;
      ST_READ:  if (abort || rd_last) state_d = ST_IDLE;
      ST_WRITE: if (wr_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next-state logic
  always_comb begin
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    nbytes_d     = nbytes_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = 1'b0;
    ic_done_d    = 1'b0;
    ls_done_d    = 1'b0;
    ic_data_d    = ic_data_q;
    ls_rdata_d   = ls_rdata_q;

    unique case (state_q)
      ST_IDLE: begin
        mem_a_d = 32'd0;
        if (grant) begin
          owner_d      = gnt_ls ? GNT_LS : GNT_IC;
          last_grant_d = gnt_ls ? GNT_LS : GNT_IC;
          addr_d       = g_addr;
          wdata_d      = ls_wdata;
          nbytes_d     = g_n;
          acc_d        = 32'd0;
          mem_a_d      = g_addr;
          if (g_wr && !g_stall) begin
            mem_wr_d   = 1'b1;
            mem_dout_d = ls_wdata[7:0];
            cnt_d      = 3'd1;
          end else if (g_wr) begin
            cnt_d = 3'd0;
          end else begin
            cnt_d = 3'd1;
          end
        end
      end

      ST_READ: begin
        if (abort) begin
          mem_a_d = 32'd0;
          cnt_d   = 3'd0;
        end else begin
          if (cnt_q >= 3'd2) acc_d[{cap_idx, 3'b000} +: 8] = mem_din;
          mem_a_d = (cnt_q < nbytes_q) ? cur_addr : 32'd0;
          if (rd_last) begin
            mem_a_d = 32'd0;
            cnt_d   = 3'd0;
            if (owner_q == GNT_IC) begin
              ic_done_d = 1'b1;
              ic_data_d = acc_d;
            end else begin
              ls_done_d  = 1'b1;
              ls_rdata_d = acc_d;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      ST_WRITE: begin
        if (wr_last) begin
          mem_a_d   = 32'd0;
          cnt_d     = 3'd0;
          ls_done_d = 1'b1;
        end else if (wr_stall) begin
          // Park on the pending byte with the strobe low until the UART drains.
          mem_a_d = cur_addr;
        end else begin
          mem_a_d    = cur_addr;
          mem_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          mem_wr_d   = 1'b1;
          cnt_d      = cnt_q + 3'd1;
        end
      end

      default: begin
        mem_a_d = 32'd0;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      owner_q      <= GNT_IC;
      last_grant_q <= GNT_IC;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      nbytes_q     <= 3'd0;
      cnt_q        <= 3'd0;
      acc_q        <= 32'd0;
      mem_a_q      <= 32'd0;
      mem_dout_q   <= 8'd0;
      mem_wr_q     <= 1'b0;
      ic_done_q    <= 1'b0;
      ls_done_q    <= 1'b0;
      ic_data_q    <= 32'd0;
      ls_rdata_q   <= 32'd0;
    end else if (rdy_in) begin
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      nbytes_q     <= nbytes_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      ic_done_q    <= ic_done_d;
      ls_done_q    <= ls_done_d;
      ic_data_q    <= ic_data_d;
      ls_rdata_q   <= ls_rdata_d;
    end
  end

  assign mem_a    = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr   = mem_wr_q;
  assign ic_done  = ic_done_q;
  assign ic_data  = ic_data_q;
  assign ls_done  = ls_done_q;
  assign ls_rdata = ls_rdata_q;

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Arbitrates the single byte-wide RAM port between the instruction cache (word refill reads) and the load/store buffer (byte/half/word loads and stores). It serialises each granted request into consecutive byte accesses, assembles read data little-endian, and pulses a per-requester done. A pipeline flush cancels instruction reads. It sits between icache/LSB and the top-level RAM/IO pins.

## Interface
- No parameters. Size encodings and IO address constants come from const.v.
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  global pause; when low, every register holds its value
- mem_din  in  8  RAM read byte, valid the cycle after its address was driven
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write, 0 = read
- io_buffer_full  in  1  UART buffer full; blocks IO-space writes
- flush  in  1  misprediction clear from ROB
- ic_req  in  1  icache read request; held until ic_done
- ic_addr  in  32  word-aligned fetch address
- ic_done  out  1  one-cycle pulse; ic_data valid
- ic_data  out  32  fetched word
- ls_req  in  1  LSB request; held until ls_done
- ls_wr  in  1  1 = store
- ls_addr  in  32  byte address
- ls_size  in  2  0 = byte, 1 = half, 2 = word
- ls_wdata  in  32  store data; low bytes used
- ls_done  out  1  one-cycle pulse
- ls_rdata  out  32  load data, zero-extended; the LSB sign-extends

## Operation
- States:
  - IDLE: no access in flight.
  - READ: byte counter cnt counts 0..N-1 addresses driven, plus a capture counter.
  - WRITE: cnt counts 0..N-1.
- N = 1, 2 or 4. ic always uses N = 4.
- IDLE with any request: grant at edge E0; latch address, size and write data; drive mem_a = addr and byte 0.
- Tie break: grant the requester that was not granted last. last_grant resets to ic, so the LSB wins the first tie.
- Only one requester is granted at a time. ic_done and ls_done are never high together.
- READ:
  - At edge Ek (k < N), drive mem_a = addr + k with mem_wr = 0.
  - Capture mem_din as byte k at edge E(k+2) into bits [8k+7:8k].
  - At edge E(N+1), assert done with data and return to IDLE.
- WRITE:
  - At edge Ek, drive mem_a = addr + k, mem_dout = wdata[8k+7:8k], mem_wr = 1.
  - At edge EN, set mem_wr = 0, assert ls_done and return to IDLE.
- IO stall: an address with addr[17:16] == 2'b11 is IO space. For an IO write while io_buffer_full = 1, hold at the current byte with mem_wr = 0 and resume when it clears. IO reads are never stalled.
- flush:
  - With an ic READ in flight: abort at the next edge, go to IDLE, mem_a = 0, no ic_done.
  - An ic_req sampled in IDLE in the same cycle as flush is not granted.
  - A flush during an LSB access has no effect; stores are never aborted.
- Address arithmetic is 32-bit and wraps modulo 2^32. Misaligned ls_addr is legal; bytes are taken sequentially.
- Reset (async, any state): state = IDLE, mem_a = 0, mem_dout = 0, mem_wr = 0, ic_done = 0, ls_done = 0, ic_data = 0, ls_rdata = 0, last_grant = ic. An access in progress is dropped.

## Timing
- Word read: request seen at E0, done pulse in the cycle after E5, i.e. 5 edges after the grant.
- Byte read: 2 edges. Word store: 4 edges. Byte store: 1 edge.
- Done is a one-cycle registered pulse. The requester deasserts or changes its request in the cycle after done.
- After done, IDLE lasts at least one edge before the next grant. This bubble is mandatory.
- When idle: mem_wr = 0 and mem_a = 0.
- rdy_in low freezes everything, including the counters and the pending done. The top level guarantees RAM is paused alongside.

## Structure
- Add to const.v: size encodings (SIZE_B/H/W), state encodings, the IO-space address compare.
- Single module. The byte-sequencing datapath is about 30 lines, so no sub-module is warranted.

## Test plan
- ic_req with addr 0x1000, RAM holding bytes 0x13, 0x05, 0x10, 0x00 → ic_done exactly 5 edges after grant, ic_data = 0x00100513. mem_a sequence is 0x1000..0x1003.
- ls store word 0xDEADBEEF to 0x2000 → mem_wr high for 4 cycles with bytes EF, BE, AD, DE at 0x2000..0x2003, ls_done at E4, then mem_wr = 0.
- ic_req and ls_req raised in the same cycle after reset → LSB granted first. ic is granted after ls_done plus one IDLE edge; neither is starved.
- flush 2 cycles into an ic read → no ic_done, state IDLE next edge. A following ls load of byte at 0x10 returns 0x000000xx correctly.
- IO store byte 0x41 to 0x30000 with io_buffer_full = 1 for 3 cycles → mem_wr stays 0, then a single write of 0x41 and ls_done.
- Reset asserted mid word-read → all outputs zero immediately. After release, a fresh request completes normally.
